// File: rtl/breg_wb_pkg.sv
// breg_wb_pkg: shared defaults and the queued writeback entry type
package breg_wb_pkg;
  localparam int BREG_WB_DEPTH = 4;
  localparam int BREG_WB_ADDR_W = 5;
  localparam int BREG_WB_DATA_W = 32;
  typedef struct packed {
    logic [BREG_WB_ADDR_W-1:0] addr;
    logic [BREG_WB_DATA_W-1:0] data;
  } wb_entry_t;
endpackage

// File: rtl/breg_writeback_if.sv
// breg_writeback_if: writeback channels, register-file write port and forwarding queries
interface breg_writeback_if #(
  parameter int DEPTH = breg_wb_pkg::BREG_WB_DEPTH,
  parameter int DATA_W = breg_wb_pkg::BREG_WB_DATA_W,
  parameter int ADDR_W = breg_wb_pkg::BREG_WB_ADDR_W
);
  logic alu_valid;
  logic alu_ready;
  logic [ADDR_W-1:0] alu_addr;
  logic [DATA_W-1:0] alu_data;
  logic ld_valid;
  logic ld_ready;
  logic [ADDR_W-1:0] ld_addr;
  logic [DATA_W-1:0] ld_data;
  logic [ADDR_W-1:0] endRD;
  logic [DATA_W-1:0] dados_Escrita;
  logic write;
  logic [ADDR_W-1:0] endRS;
  logic [ADDR_W-1:0] endRT;
  logic fwd_rs_hit;
  logic fwd_rt_hit;
  logic [DATA_W-1:0] fwd_rs_data;
  logic [DATA_W-1:0] fwd_rt_data;
  logic [$clog2(DEPTH):0] count;
  logic full;
  modport slave (
    input alu_valid, alu_addr, alu_data, ld_valid, ld_addr, ld_data, endRS, endRT,
    output alu_ready, ld_ready, endRD, dados_Escrita, write,
    output fwd_rs_hit, fwd_rt_hit, fwd_rs_data, fwd_rt_data, count, full
  );
  modport master (
    output alu_valid, alu_addr, alu_data, ld_valid, ld_addr, ld_data, endRS, endRT,
    input alu_ready, ld_ready, endRD, dados_Escrita, write,
    input fwd_rs_hit, fwd_rt_hit, fwd_rs_data, fwd_rt_data, count, full
  );
endinterface

// File: rtl/breg_wb_fifo.sv
// breg_wb_fifo: dual-push / single-pop entry queue; exposes storage and occupancy for forwarding search
module breg_wb_fifo import breg_wb_pkg::*; #(
  parameter int DEPTH = BREG_WB_DEPTH,
  localparam int PW = $clog2(DEPTH),
  localparam int CW = PW + 1
) (
  input  logic clock,
  input  logic reset,
  input  logic push0,
  input  wb_entry_t e0,
  input  logic push1,
  input  wb_entry_t e1,
  input  logic pop,
  output wb_entry_t ent [DEPTH],
  output logic [DEPTH-1:0] valid,
  output logic [PW-1:0] rd_ptr,
  output logic [CW-1:0] count
);
  wb_entry_t mem_q [DEPTH];
  wb_entry_t mem_d [DEPTH];
  logic [PW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;
  logic do_pop;
  assign do_pop = pop && count_q != '0;
  // pushes are compacted onto the tail with push0 older; the head retires on pop
  always_comb begin
    mem_d = mem_q;
    if (push0 || push1) mem_d[wr_ptr_q] = push0 ? e0 : e1;
    if (push0 && push1) mem_d[wr_ptr_q + PW'(1)] = e1;
    wr_ptr_d = wr_ptr_q + PW'(push0) + PW'(push1);
    rd_ptr_d = rd_ptr_q + PW'(do_pop);
    count_d = count_q + CW'(push0) + CW'(push1) - CW'(do_pop);
  end
  // slot i is occupied when its distance from the head is below the count
  always_comb begin
    for (int i = 0; i < DEPTH; i++) valid[i] = {1'b0, PW'(i) - rd_ptr_q} < count_q;
  end
  // storage and pointers; reset empties the queue immediately
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      mem_q <= '{default: '0};
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q <= '0;
    end else begin
      mem_q <= mem_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q <= count_d;
    end
  end
  assign ent = mem_q;
  assign rd_ptr = rd_ptr_q;
  assign count = count_q;
endmodule

// File: rtl/breg_writeback.sv
// breg_writeback: queues ALU/load writebacks and drains one per cycle to the register-file write port.
// Define BREG_WB_FORWARD_EN to build the forwarding search; otherwise the fwd outputs read 0.
module breg_writeback import breg_wb_pkg::*; #(
  parameter int DEPTH = BREG_WB_DEPTH,
  parameter int DATA_W = BREG_WB_DATA_W,
  parameter int ADDR_W = BREG_WB_ADDR_W,
  localparam int PW = $clog2(DEPTH),
  localparam int CW = PW + 1
) (
  input logic clock,
  input logic reset,
  breg_writeback_if.slave bus
);
  wb_entry_t ent [DEPTH];
  wb_entry_t head;
  logic [DEPTH-1:0] valid;
  logic [PW-1:0] rd_ptr;
  logic [CW-1:0] count, free;
  logic ld_ready, alu_ready, ld_push, alu_push, pop;
  assign free = CW'(DEPTH) - count;
  assign ld_ready = free >= CW'(1);
  assign alu_ready = free >= CW'(2);
  assign ld_push = bus.ld_valid && ld_ready && |bus.ld_addr;
  assign alu_push = bus.alu_valid && alu_ready && |bus.alu_addr;
  breg_wb_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clock(clock),
    .reset(reset),
    .push0(ld_push),
    .e0('{addr: bus.ld_addr, data: bus.ld_data}),
    .push1(alu_push),
    .e1('{addr: bus.alu_addr, data: bus.alu_data}),
    .pop(pop),
    .ent(ent),
    .valid(valid),
    .rd_ptr(rd_ptr),
    .count(count)
  );
  assign head = ent[rd_ptr];
  assign pop = valid[rd_ptr];
  assign bus.ld_ready = ld_ready;
  assign bus.alu_ready = alu_ready;
  assign bus.write = pop;
  assign bus.endRD = pop ? head.addr : '0;
  assign bus.dados_Escrita = pop ? head.data : '0;
  assign bus.count = count;
  assign bus.full = count == CW'(DEPTH);
`ifdef BREG_WB_FORWARD_EN
  logic rs_hit, rt_hit;
  logic [DATA_W-1:0] rs_data, rt_data;
  // scan head to tail so the youngest matching entry overrides older ones
  always_comb begin
    rs_hit = 1'b0;
    rt_hit = 1'b0;
    rs_data = '0;
    rt_data = '0;
    for (int k = 0; k < DEPTH; k++) begin
      if (valid[rd_ptr + PW'(k)] && |bus.endRS && ent[rd_ptr + PW'(k)].addr == bus.endRS) begin
        rs_hit = 1'b1;
        rs_data = ent[rd_ptr + PW'(k)].data;
      end
      if (valid[rd_ptr + PW'(k)] && |bus.endRT && ent[rd_ptr + PW'(k)].addr == bus.endRT) begin
        rt_hit = 1'b1;
        rt_data = ent[rd_ptr + PW'(k)].data;
      end
    end
  end
  assign bus.fwd_rs_hit = rs_hit;
  assign bus.fwd_rt_hit = rt_hit;
  assign bus.fwd_rs_data = rs_data;
  assign bus.fwd_rt_data = rt_data;
`else
  logic unused_fwd;
  assign unused_fwd = ^{bus.endRS, bus.endRT};
  assign bus.fwd_rs_hit = 1'b0;
  assign bus.fwd_rt_hit = 1'b0;
  assign bus.fwd_rs_data = '0;
  assign bus.fwd_rt_data = '0;
`endif
endmodule

// File: tb/tb_breg_writeback.sv
// tb_breg_writeback: table vectors, reset corner case and random traffic against a queue model
module tb_breg_writeback;
  localparam int DEPTH = 4;
`ifdef BREG_WB_FORWARD_EN
  localparam bit FWD = 1'b1;
`else
  localparam bit FWD = 1'b0;
`endif
  typedef struct {
    logic ldv;
    logic [4:0] lda;
    logic [31:0] ldd;
    logic aluv;
    logic [4:0] alua;
    logic [31:0] alud;
    logic [4:0] rs;
    logic [4:0] rt;
    logic ew;
    logic [4:0] erd;
    logic [31:0] edat;
    int ecnt;
    logic elr;
    logic ear;
    logic ehit;
    logic [31:0] ehd;
  } vec_t;
  typedef struct packed {
    logic [4:0] a;
    logic [31:0] d;
  } ent_t;
  logic clock;
  logic reset;
  int total = 0;
  int passes = 0;
  int fails = 0;
  ent_t q[$];
  vec_t tbl[$];
  breg_writeback_if #(.DEPTH(DEPTH), .DATA_W(32), .ADDR_W(5)) bus ();
  breg_writeback dut (.clock(clock), .reset(reset), .bus(bus.slave));
  initial clock = 1'b0;
  always #5 clock = ~clock;
  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end
  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act === exp) passes++;
    else begin
      fails++;
      $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
    end
  endtask
  function automatic vec_t mk(input int ldv, input int lda, input int ldd, input int aluv,
                              input int alua, input int alud, input int rs, input int ew,
                              input int erd, input int edat, input int ecnt, input int elr,
                              input int ear, input int ehit, input int ehd);
    vec_t r;
    r.ldv = 1'(ldv); r.lda = 5'(lda); r.ldd = 32'(ldd);
    r.aluv = 1'(aluv); r.alua = 5'(alua); r.alud = 32'(alud);
    r.rs = 5'(rs); r.rt = 5'(rs);
    r.ew = 1'(ew); r.erd = 5'(erd); r.edat = 32'(edat); r.ecnt = ecnt;
    r.elr = 1'(elr); r.ear = 1'(ear); r.ehit = 1'(ehit); r.ehd = 32'(ehd);
    return r;
  endfunction
  // one cycle: drive at negedge, compare against the queue model, advance the model at posedge
  task automatic step(input vec_t v, input bit use_tbl, input string tag);
    int n;
    bit lr, ar, hrs, hrt;
    logic [31:0] drs, drt, hd;
    logic [4:0] ha;
    bus.ld_valid = v.ldv; bus.ld_addr = v.lda; bus.ld_data = v.ldd;
    bus.alu_valid = v.aluv; bus.alu_addr = v.alua; bus.alu_data = v.alud;
    bus.endRS = v.rs; bus.endRT = v.rt;
    #1;
    n = q.size();
    lr = (DEPTH - n) >= 1;
    ar = (DEPTH - n) >= 2;
    ha = '0; hd = '0;
    if (n > 0) begin ha = q[0].a; hd = q[0].d; end
    hrs = 0; hrt = 0; drs = '0; drt = '0;
    foreach (q[i]) begin
      if (v.rs != 0 && q[i].a == v.rs) begin hrs = 1; drs = q[i].d; end
      if (v.rt != 0 && q[i].a == v.rt) begin hrt = 1; drt = q[i].d; end
    end
    chk({tag, "_ld_ready"}, 32'(bus.ld_ready), 32'(lr));
    chk({tag, "_alu_ready"}, 32'(bus.alu_ready), 32'(ar));
    chk({tag, "_write"}, 32'(bus.write), 32'(n > 0));
    chk({tag, "_endRD"}, 32'(bus.endRD), 32'(ha));
    chk({tag, "_dados"}, bus.dados_Escrita, hd);
    chk({tag, "_count"}, 32'(bus.count), n);
    chk({tag, "_full"}, 32'(bus.full), 32'(n == DEPTH));
    chk({tag, "_rs_hit"}, 32'(bus.fwd_rs_hit), 32'(FWD & hrs));
    chk({tag, "_rs_data"}, bus.fwd_rs_data, FWD ? drs : 32'h0);
    chk({tag, "_rt_hit"}, 32'(bus.fwd_rt_hit), 32'(FWD & hrt));
    chk({tag, "_rt_data"}, bus.fwd_rt_data, FWD ? drt : 32'h0);
    if (use_tbl) begin
      chk({tag, "_tbl_write"}, 32'(bus.write), 32'(v.ew));
      chk({tag, "_tbl_endRD"}, 32'(bus.endRD), 32'(v.erd));
      chk({tag, "_tbl_dados"}, bus.dados_Escrita, v.edat);
      chk({tag, "_tbl_count"}, 32'(bus.count), v.ecnt);
      chk({tag, "_tbl_ld_ready"}, 32'(bus.ld_ready), 32'(v.elr));
      chk({tag, "_tbl_alu_ready"}, 32'(bus.alu_ready), 32'(v.ear));
      chk({tag, "_tbl_rs_hit"}, 32'(bus.fwd_rs_hit), 32'(FWD & v.ehit));
      chk({tag, "_tbl_rs_data"}, bus.fwd_rs_data, FWD ? v.ehd : 32'h0);
    end
    @(posedge clock);
    if (n > 0) void'(q.pop_front());
    if (v.ldv && lr && v.lda != 0) q.push_back({v.lda, v.ldd});
    if (v.aluv && ar && v.alua != 0) q.push_back({v.alua, v.alud});
    @(negedge clock);
  endtask
  task automatic check_reset_state(input string tag);
    chk({tag, "_write"}, 32'(bus.write), 32'h0);
    chk({tag, "_endRD"}, 32'(bus.endRD), 32'h0);
    chk({tag, "_dados"}, bus.dados_Escrita, 32'h0);
    chk({tag, "_count"}, 32'(bus.count), 32'h0);
    chk({tag, "_full"}, 32'(bus.full), 32'h0);
    chk({tag, "_ld_ready"}, 32'(bus.ld_ready), 32'h1);
    chk({tag, "_alu_ready"}, 32'(bus.alu_ready), 32'h1);
    chk({tag, "_rs_hit"}, 32'(bus.fwd_rs_hit), 32'h0);
    chk({tag, "_rt_hit"}, 32'(bus.fwd_rt_hit), 32'h0);
    chk({tag, "_rs_data"}, bus.fwd_rs_data, 32'h0);
  endtask
  initial begin
    vec_t v;
    reset = 1'b1;
    bus.ld_valid = 0; bus.ld_addr = '0; bus.ld_data = '0;
    bus.alu_valid = 0; bus.alu_addr = '0; bus.alu_data = '0;
    bus.endRS = '0; bus.endRT = '0;
    repeat (2) @(negedge clock);
    #1;
    check_reset_state("reset");
    @(negedge clock);
    reset = 1'b0;
    //        ld v,a,d           alu v,a,d              rs | w,rd,data,        cnt,lr,ar,hit,hdata
    tbl.push_back(mk(0, 0, 0,    1, 5, 32'hDEADBEEF, 5,  0, 0, 0,            0, 1, 1, 0, 0));
    tbl.push_back(mk(0, 0, 0,    0, 0, 0,            5,  1, 5, 32'hDEADBEEF, 1, 1, 1, 1, 32'hDEADBEEF));
    tbl.push_back(mk(0, 0, 0,    0, 0, 0,            5,  0, 0, 0,            0, 1, 1, 0, 0));
    tbl.push_back(mk(1, 3, 'h11, 1, 3, 'h22,         3,  0, 0, 0,            0, 1, 1, 0, 0));
    tbl.push_back(mk(0, 0, 0,    0, 0, 0,            3,  1, 3, 'h11,         2, 1, 1, 1, 'h22));
    tbl.push_back(mk(0, 0, 0,    0, 0, 0,            3,  1, 3, 'h22,         1, 1, 1, 1, 'h22));
    tbl.push_back(mk(0, 0, 0,    0, 0, 0,            3,  0, 0, 0,            0, 1, 1, 0, 0));
    tbl.push_back(mk(0, 0, 0,    1, 0, 'h55,         0,  0, 0, 0,            0, 1, 1, 0, 0));
    tbl.push_back(mk(0, 0, 0,    0, 0, 0,            0,  0, 0, 0,            0, 1, 1, 0, 0));
    tbl.push_back(mk(1, 1, 1,    1, 2, 2,            2,  0, 0, 0,            0, 1, 1, 0, 0));
    tbl.push_back(mk(1, 3, 3,    1, 4, 4,            2,  1, 1, 1,            2, 1, 1, 1, 2));
    tbl.push_back(mk(1, 5, 5,    1, 6, 6,            4,  1, 2, 2,            3, 1, 0, 1, 4));
    tbl.push_back(mk(1, 7, 7,    1, 6, 6,            6,  1, 3, 3,            3, 1, 0, 0, 0));
    tbl.push_back(mk(0, 0, 0,    0, 0, 0,            7,  1, 4, 4,            3, 1, 0, 1, 7));
    tbl.push_back(mk(0, 0, 0,    0, 0, 0,            5,  1, 5, 5,            2, 1, 1, 1, 5));
    tbl.push_back(mk(0, 0, 0,    0, 0, 0,            7,  1, 7, 7,            1, 1, 1, 1, 7));
    tbl.push_back(mk(0, 0, 0,    0, 0, 0,            0,  0, 0, 0,            0, 1, 1, 0, 0));
    foreach (tbl[i]) step(tbl[i], 1'b1, $sformatf("row%0d", i));
    step(mk(1, 1, 'hA1, 1, 2, 'hA2, 4, 0, 0, 0, 0, 0, 0, 0, 0), 1'b0, "pre0");
    step(mk(1, 3, 'hA3, 1, 4, 'hA4, 4, 0, 0, 0, 0, 0, 0, 0, 0), 1'b0, "pre1");
    bus.endRS = 5'd4; bus.endRT = 5'd3;
    #1;
    chk("pre_reset_count", 32'(bus.count), 32'd3);
    #1;
    reset = 1'b1;
    #1;
    check_reset_state("mid_reset");
    q.delete();
    @(posedge clock);
    @(negedge clock);
    reset = 1'b0;
    step(mk(0, 0, 0, 1, 7, 7, 7, 0, 0, 0, 0, 1, 1, 0, 0), 1'b1, "post0");
    step(mk(0, 0, 0, 0, 0, 0, 7, 1, 7, 7, 1, 1, 1, 1, 7), 1'b1, "post1");
    step(mk(0, 0, 0, 0, 0, 0, 7, 0, 0, 0, 0, 1, 1, 0, 0), 1'b1, "post2");
    for (int i = 0; i < 300; i++) begin
      v = mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
      v.ldv = 1'($urandom_range(0, 3) != 0);
      v.lda = 5'($urandom_range(0, 7));
      v.ldd = $urandom;
      v.aluv = 1'($urandom_range(0, 3) != 0);
      v.alua = 5'($urandom_range(0, 7));
      v.alud = $urandom;
      v.rs = 5'($urandom_range(0, 7));
      v.rt = 5'($urandom_range(0, 7));
      step(v, 1'b0, "rnd");
    end
    $display("%0d/%0d checks passed", passes, total);
    $finish;
  end
endmodule
